// File: rtl/sobel_frame_packer_if.sv
// sobel_frame_packer_if
//   Stream interface between the Sobel gradient source, the frame packer and
//   the host-bound packet path.
//   Pixel side : in_valid, in_data[7:0], in_last
//   Word side  : out_valid, out_data[8*PIX_PER_WORD-1:0], out_keep, out_last
//   Status     : len_err (sticky), frame_cnt[15:0]
//   master : drives the pixel stream, observes words and status
//   slave  : the packer (consumes pixels, produces words and status)
interface sobel_frame_packer_if #(
  parameter int PIX_PER_WORD = 8
);
  logic                      in_valid;
  logic [7:0]                in_data;
  logic                      in_last;
  logic                      out_valid;
  logic [8*PIX_PER_WORD-1:0] out_data;
  logic [PIX_PER_WORD-1:0]   out_keep;
  logic                      out_last;
  logic                      len_err;
  logic [15:0]               frame_cnt;

  modport master (
    output in_valid, in_data, in_last,
    input  out_valid, out_data, out_keep, out_last, len_err, frame_cnt
  );

  modport slave (
    input  in_valid, in_data, in_last,
    output out_valid, out_data, out_keep, out_last, len_err, frame_cnt
  );
endinterface

// File: rtl/sobel_frame_packer.sv
// sobel_frame_packer
//   Takes the per-pixel Sobel gradient stream, zeroes the leading BORDER
//   rows/columns, and packs PIX_PER_WORD pixels into one wide word. Partial
//   words are flushed at frame end; frame-length errors are flagged (sticky).
//   Ports: clk, rst (async, active-high), bus (sobel_frame_packer_if.slave).
//   Optional: define SOBEL_PACK_THRESHOLD_EN to binarize interior pixels
//   against THRESHOLD (pixel > THRESHOLD -> 8'hFF, else 8'h00).
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   ACCUM | no word presented this cycle; pixels fill the staging word
//   EMIT  | one-cycle output stage: out_* holds a freshly packed word
//   Pixel accumulation continues in both states, so back-to-back EMIT
//   cycles are possible.
module sobel_frame_packer #(
  parameter int IMG_WIDTH    = 640,
  parameter int IMG_HEIGHT   = 480,
  parameter int BORDER       = 2,
  parameter int PIX_PER_WORD = 8
`ifdef SOBEL_PACK_THRESHOLD_EN
  , parameter logic [7:0] THRESHOLD = 8'h55
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  sobel_frame_packer_if.slave   bus
);

  localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int SW = $clog2(PIX_PER_WORD);
  localparam int DW = 8 * PIX_PER_WORD;

  localparam logic [CW-1:0]           COL_LAST  = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0]           ROW_LAST  = RW'(IMG_HEIGHT - 1);
  localparam logic [SW-1:0]           SLOT_LAST = SW'(PIX_PER_WORD - 1);
  localparam logic [PIX_PER_WORD-1:0] KEEP_ALL  = '1;

  typedef enum logic {ACCUM, EMIT} state_e;

  state_e                  state_q;
  logic [CW-1:0]           col_q;
  logic [RW-1:0]           row_q;
  logic [SW-1:0]           slot_q;
  logic [DW-1:0]           stage_q;
  logic [DW-1:0]           out_data_q;
  logic [PIX_PER_WORD-1:0] out_keep_q;
  logic                    out_last_q;
  logic                    len_err_q;
  logic [15:0]             frame_cnt_q;

  logic [7:0]              pix_d;
  logic                    at_end;
  logic                    eof;
  logic                    word_done;
  logic [DW-1:0]           stage_d;
  logic [PIX_PER_WORD-1:0] keep_d;

  always_comb begin
    pix_d = (int'(col_q) < BORDER || int'(row_q) < BORDER) ? 8'h00 : bus.in_data;
`ifdef SOBEL_PACK_THRESHOLD_EN
    pix_d = (pix_d > THRESHOLD) ? 8'hFF : 8'h00;
`endif
    at_end    = (col_q == COL_LAST) && (row_q == ROW_LAST);
    eof       = bus.in_last || at_end;
    word_done = (slot_q == SLOT_LAST) || eof;
    // staging word including the current pixel; unfilled slots are already 0
    stage_d = stage_q;
    stage_d[{slot_q, 3'b000} +: 8] = pix_d;
    keep_d  = KEEP_ALL >> (SLOT_LAST - slot_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ACCUM;
      col_q       <= '0;
      row_q       <= '0;
      slot_q      <= '0;
      stage_q     <= '0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_last_q  <= 1'b0;
      len_err_q   <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q <= ACCUM;
      if (bus.in_valid) begin
        if (word_done) begin
          state_q    <= EMIT;
          out_data_q <= stage_d;
          out_keep_q <= keep_d;
          out_last_q <= eof;
          stage_q    <= '0;
          slot_q     <= '0;
        end else begin
          stage_q <= stage_d;
          slot_q  <= slot_q + SW'(1);
        end

        if (eof) begin
          col_q       <= '0;
          row_q       <= '0;
          frame_cnt_q <= frame_cnt_q + 16'd1;
          // early in_last or a missing in_last both end the frame, but flag it
          if (bus.in_last != at_end) len_err_q <= 1'b1;
        end else if (col_q == COL_LAST) begin
          col_q <= '0;
          row_q <= row_q + RW'(1);
        end else begin
          col_q <= col_q + CW'(1);
        end
      end
    end
  end

  assign bus.out_valid = (state_q == EMIT);
  assign bus.out_data  = out_data_q;
  assign bus.out_keep  = out_keep_q;
  assign bus.out_last  = out_last_q;
  assign bus.len_err   = len_err_q;
  assign bus.frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_sobel_frame_packer.sv
// tb_sobel_frame_packer
//   Directed frame vectors on an 8x4 image, BORDER=2, PIX_PER_WORD=8.
//   Each vector lists the pixel stream shape and the words it must produce;
//   a reset-mid-frame sequence is written out by hand.
module tb_sobel_frame_packer;

  localparam int PPW = 8;

`ifdef SOBEL_PACK_THRESHOLD_EN
  localparam logic [63:0] W_INT = 64'h0000_0000_0000_0000;
  localparam logic [63:0] W_ALT = 64'hFF00_FF00_FF00_0000;
`else
  localparam logic [63:0] W_INT = 64'h4040_4040_4040_0000;
  localparam logic [63:0] W_ALT = 64'h5655_5655_5655_0000;
`endif

  logic clk;
  logic rst;
  int   cyc;

  sobel_frame_packer_if #(.PIX_PER_WORD(PPW)) bus ();

  sobel_frame_packer #(
    .IMG_WIDTH(8), .IMG_HEIGHT(4), .BORDER(2), .PIX_PER_WORD(PPW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
    int          c;
  } obs_t;

  obs_t obs[$];

  always @(negedge clk) begin
    if (bus.out_valid === 1'b1) begin
      obs_t o;
      o.d = bus.out_data;
      o.k = bus.out_keep;
      o.l = bus.out_last;
      o.c = cyc;
      obs.push_back(o);
    end
  end

  typedef struct {
    int              npix;
    int              last_at;   // -1: in_last never asserted
    bit              gaps;
    bit              pat;       // 0: all 8'h40, 1: 8'h55/8'h56 alternating
    int              nwords;
    logic [3:0][63:0] data;
    logic [3:0][7:0]  keep;
    logic [3:0]       lastv;
    logic [3:0][7:0]  endp;     // pixel index that completes each word
    logic             le;
  } vec_t;

  vec_t vecs[5];
  int   pix_cyc[64];
  int   n_cmp;
  int   n_err;
  logic [15:0] exp_fc;
  logic        exp_le;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk_full(input int last_at, input bit gaps, input bit pat,
                                   input logic le);
    vec_t v;
    v.npix    = 32;
    v.last_at = last_at;
    v.gaps    = gaps;
    v.pat     = pat;
    v.nwords  = 4;
    v.data[0] = 64'h0;
    v.data[1] = 64'h0;
    v.data[2] = pat ? W_ALT : W_INT;
    v.data[3] = pat ? W_ALT : W_INT;
    v.keep    = {4{8'hFF}};
    v.lastv   = 4'b1000;
    v.endp[0] = 8'd7;
    v.endp[1] = 8'd15;
    v.endp[2] = 8'd23;
    v.endp[3] = 8'd31;
    v.le      = le;
    return v;
  endfunction

  task automatic idle_inputs();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b1;   // ignored while in_valid is low
    bus.in_data  = 8'hEE;
  endtask

  task automatic drive_pix(input logic [7:0] d, input logic l, output int c);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    @(posedge clk);
    #1;
    c = cyc;
    idle_inputs();
  endtask

  task automatic run_vec(input int v);
    int          c;
    int          g;
    logic [7:0]  d;
    obs.delete();
    for (int i = 0; i < vecs[v].npix; i++) begin
      if (vecs[v].gaps) begin
        g = 0;
        while (g < 3 && $urandom_range(0, 1) == 1) g++;
        repeat (g) begin @(posedge clk); #1; end
      end
      if (vecs[v].pat) d = (i % 2 == 0) ? 8'h55 : 8'h56;
      else             d = 8'h40;
      drive_pix(d, (i == vecs[v].last_at), c);
      pix_cyc[i] = c;
    end
    repeat (3) begin @(posedge clk); #1; end
    exp_fc = exp_fc + 16'd1;
    exp_le = exp_le | vecs[v].le;
    chk($sformatf("v%0d word_count", v), 64'(obs.size()), 64'(vecs[v].nwords));
    for (int w = 0; w < vecs[v].nwords; w++) begin
      if (w < obs.size()) begin
        chk($sformatf("v%0d w%0d data", v, w), obs[w].d, vecs[v].data[w]);
        chk($sformatf("v%0d w%0d keep", v, w), 64'(obs[w].k), 64'(vecs[v].keep[w]));
        chk($sformatf("v%0d w%0d last", v, w), 64'(obs[w].l), 64'(vecs[v].lastv[w]));
        chk($sformatf("v%0d w%0d latency_cycle", v, w), 64'(obs[w].c),
            64'(pix_cyc[vecs[v].endp[w]]));
      end
    end
    chk($sformatf("v%0d len_err", v), 64'(bus.len_err), 64'(exp_le));
    chk($sformatf("v%0d frame_cnt", v), 64'(bus.frame_cnt), 64'(exp_fc));
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, " out_valid"}, 64'(bus.out_valid), 64'h0);
    chk({tag, " out_data"},  bus.out_data,       64'h0);
    chk({tag, " out_keep"},  64'(bus.out_keep),  64'h0);
    chk({tag, " out_last"},  64'(bus.out_last),  64'h0);
    chk({tag, " len_err"},   64'(bus.len_err),   64'h0);
    chk({tag, " frame_cnt"}, 64'(bus.frame_cnt), 64'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c;
    n_cmp  = 0;
    n_err  = 0;
    cyc    = 0;
    exp_fc = '0;
    exp_le = 1'b0;

    vecs[0] = mk_full(31, 1'b0, 1'b0, 1'b0);
    vecs[1] = mk_full(31, 1'b1, 1'b0, 1'b0);
    vecs[2] = mk_full(12, 1'b0, 1'b0, 1'b1);
    vecs[2].npix    = 13;
    vecs[2].nwords  = 2;
    vecs[2].data[1] = 64'h0;
    vecs[2].keep[1] = 8'h1F;
    vecs[2].lastv   = 4'b0010;
    vecs[2].endp[1] = 8'd12;
    vecs[3] = mk_full(-1, 1'b0, 1'b0, 1'b1);
    vecs[4] = mk_full(31, 1'b0, 1'b1, 1'b0);

    rst = 1'b1;
    idle_inputs();
    repeat (3) begin @(posedge clk); #1; end
    chk_outputs_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    run_vec(0);
    run_vec(1);
    run_vec(2);
    run_vec(3);

    // reset in the middle of a frame: partial word is discarded silently
    obs.delete();
    for (int i = 0; i < 5; i++) drive_pix(8'h40, 1'b0, c);
    rst = 1'b1;
    #1;
    chk_outputs_zero("midreset");
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    chk("midreset no_words", 64'(obs.size()), 64'h0);
    exp_fc = '0;
    exp_le = 1'b0;

    run_vec(0);
    run_vec(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
